mem_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer placed in front of the single-port `memory` block. It accepts read/write requests from two independent masters and latches one request at a time. It drives the memory's valid/ready handshake and returns read data to the granted master. A watchdog aborts any access the memory never acknowledges.

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter that serialises reads and writes onto one
// single-port memory, with a watchdog that aborts accesses the memory never acknowledges.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  r0_valid_i,
  input  logic                  r0_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] r0_addr_i,
  input  logic [DATA_WIDTH-1:0] r0_wdata_i,
  output logic                  r0_ready_o,
  output logic [DATA_WIDTH-1:0] r0_rdata_o,
  output logic                  r0_err_o,
  input  logic                  r1_valid_i,
  input  logic                  r1_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [DATA_WIDTH-1:0] r1_wdata_i,
  output logic                  r1_ready_o,
  output logic [DATA_WIDTH-1:0] r1_rdata_o,
  output logic                  r1_err_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  grant_o,
  output logic                  busy_o
);

  localparam bit WDOG_EN = (TIMEOUT > 0);
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort fires in the BUSY cycle where the count of stalled cycles reaches TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic [CNT_W-1:0]      tmo_cnt;
  logic                  any_req;
  logic                  pick;
  logic                  tmo_hit;
  logic [DATA_WIDTH-1:0] cap_data;

  always_comb begin
    any_req = r0_valid_i | r1_valid_i;
    if (r0_valid_i && r1_valid_i) begin
      pick = ~last_grant;
    end else begin
      pick = r1_valid_i;
    end
    tmo_hit  = WDOG_EN && (tmo_cnt == CNT_LAST);
    cap_data = mem_wr_rd_o ? '0 : mem_rdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      tmo_cnt     <= '0;
      grant_o     <= 1'b0;
      busy_o      <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_wr_rd_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      r0_ready_o  <= 1'b0;
      r0_rdata_o  <= '0;
      r0_err_o    <= 1'b0;
      r1_ready_o  <= 1'b0;
      r1_rdata_o  <= '0;
      r1_err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= BUSY;
            busy_o      <= 1'b1;
            grant_o     <= pick;
            mem_valid_o <= 1'b1;
            mem_wr_rd_o <= pick ? r1_wr_rd_i : r0_wr_rd_i;
            mem_addr_o  <= pick ? r1_addr_i  : r0_addr_i;
            mem_wdata_o <= pick ? r1_wdata_i : r0_wdata_i;
            tmo_cnt     <= '0;
          end
        end
        BUSY: begin
          // An acknowledge in the abort cycle still counts as a clean completion.
          if (mem_ready_i || tmo_hit) begin
            state       <= RESP;
            mem_valid_o <= 1'b0;
            if (grant_o) begin
              r1_ready_o <= 1'b1;
              r1_rdata_o <= mem_ready_i ? cap_data : '0;
              r1_err_o   <= ~mem_ready_i;
            end else begin
              r0_ready_o <= 1'b1;
              r0_rdata_o <= mem_ready_i ? cap_data : '0;
              r0_err_o   <= ~mem_ready_i;
            end
          end else if (WDOG_EN) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          busy_o     <= 1'b0;
          last_grant <= grant_o;
          r0_ready_o <= 1'b0;
          r0_rdata_o <= '0;
          r0_err_o   <= 1'b0;
          r1_ready_o <= 1'b0;
          r1_rdata_o <= '0;
          r1_err_o   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: a bench-side memory answers the
// DUT, and a transaction-level model predicts grant order, data, error and completion cycle.
module tb_mem_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          r0_valid_i, r0_wr_rd_i, r1_valid_i, r1_wr_rd_i;
  logic [AW-1:0] r0_addr_i, r1_addr_i;
  logic [DW-1:0] r0_wdata_i, r1_wdata_i;
  logic          r0_ready_o, r0_err_o, r1_ready_o, r1_err_o;
  logic [DW-1:0] r0_rdata_o, r1_rdata_o;
  logic          mem_valid_o, mem_wr_rd_o, mem_ready_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic          grant_o, busy_o;

  typedef struct {
    int            req;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            err;
    int            done;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] storage [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  int            cyc = 0;
  int            stall_cfg = 0;
  int            wait_cnt = 0;
  int            m_last = 1;
  int            last_done = -10;
  int            n_compared = 0;
  int            n_mismatched = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .r0_valid_i(r0_valid_i), .r0_wr_rd_i(r0_wr_rd_i), .r0_addr_i(r0_addr_i),
    .r0_wdata_i(r0_wdata_i), .r0_ready_o(r0_ready_o), .r0_rdata_o(r0_rdata_o),
    .r0_err_o(r0_err_o),
    .r1_valid_i(r1_valid_i), .r1_wr_rd_i(r1_wr_rd_i), .r1_addr_i(r1_addr_i),
    .r1_wdata_i(r1_wdata_i), .r1_ready_o(r1_ready_o), .r1_rdata_o(r1_rdata_o),
    .r1_err_o(r1_err_o),
    .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {24'b0, r0_ready_o, r0_err_o, r1_ready_o, r1_err_o,
                                 mem_valid_o, mem_wr_rd_o, grant_o, busy_o}, 32'd0);
    checkOutput({tag, "_r0_rdata"}, 32'(r0_rdata_o), 32'd0);
    checkOutput({tag, "_r1_rdata"}, 32'(r1_rdata_o), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata_o), 32'd0);
  endtask

  // Memory stand-in: acknowledges after stall_cfg wait cycles, toggles ready randomly when idle.
  always @(negedge clk_i) begin
    if (mem_valid_o && !rst_i) begin
      if (wait_cnt >= stall_cfg) begin
        mem_ready_i = 1'b1;
        mem_rdata_i = storage[mem_addr_o];
      end else begin
        mem_ready_i = 1'b0;
        mem_rdata_i = DW'($urandom);
      end
      wait_cnt++;
    end else begin
      wait_cnt    = 0;
      mem_ready_i = 1'($urandom_range(0, 1));
      mem_rdata_i = DW'($urandom);
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i && mem_valid_o && mem_ready_i && mem_wr_rd_o) storage[mem_addr_o] = mem_wdata_o;
  end

  // Model: each access occupies sample edge + BUSY cycles + RESP; ties go to the non-last winner.
  task automatic predictRound(input bit v0, input bit v1, input bit w0, input bit w1,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1, input int stall);
    int   g, first, n;
    exp_t e;
    g     = (cyc > last_done) ? cyc : last_done + 1;
    first = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v1 ? 1 : 0);
    n     = (v0 && v1) ? 2 : 1;
    for (int k = 0; k < n; k++) begin
      e.req   = (k == 0) ? first : 1 - first;
      e.wr    = (e.req == 1) ? w1 : w0;
      e.addr  = (e.req == 1) ? a1 : a0;
      e.wdata = (e.req == 1) ? d1 : d0;
      if (stall + 1 <= TMO) begin
        e.err  = 1'b0;
        e.done = g + stall + 2;
        if (e.wr) begin
          e.rdata          = '0;
          ref_mem[e.addr]  = e.wdata;
        end else begin
          e.rdata = ref_mem[e.addr];
        end
      end else begin
        e.err   = 1'b1;
        e.rdata = '0;
        e.done  = g + TMO + 1;
      end
      sb.push_back(e);
      m_last    = e.req;
      last_done = e.done;
      g         = e.done + 1;
    end
  endtask

  task automatic applyStimulus(input bit v0, input bit v1, input bit w0, input bit w1,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1, input int stall);
    bit pend0, pend1;
    stall_cfg  = stall;
    r0_valid_i = v0; r0_wr_rd_i = w0; r0_addr_i = a0; r0_wdata_i = d0;
    r1_valid_i = v1; r1_wr_rd_i = w1; r1_addr_i = a1; r1_wdata_i = d1;
    predictRound(v0, v1, w0, w1, a0, a1, d0, d1, stall);
    pend0 = v0;
    pend1 = v1;
    for (int t = 0; t < 80 && (pend0 || pend1); t++) begin
      @(negedge clk_i);
      if (pend0 && r0_ready_o) begin pend0 = 1'b0; r0_valid_i = 1'b0; end
      if (pend1 && r1_ready_o) begin pend1 = 1'b0; r1_valid_i = 1'b0; end
    end
    checkOutput("completion_wait", {30'b0, pend0, pend1}, 32'd0);
    if (pend0 || pend1) begin
      r0_valid_i = 1'b0;
      r1_valid_i = 1'b0;
      sb.delete();
    end
  endtask

  task automatic resetMidAccess();
    stall_cfg  = 1000;
    r1_valid_i = 1'b1; r1_wr_rd_i = 1'b1; r1_addr_i = 10'h3A7; r1_wdata_i = 16'hC0DE;
    predictRound(1'b0, 1'b1, 1'b0, 1'b1, '0, 10'h3A7, '0, 16'hC0DE, 1000);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1 checkAllZero("async_reset");
    sb.delete();
    r1_valid_i = 1'b0;
    m_last     = 1;
    last_done  = -10;
    stall_cfg  = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (TMO + 4) @(negedge clk_i);
  endtask

  // Monitor: pops the scoreboard on every completion and checks the in-flight access each BUSY cycle.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (!rst_i) begin
      if (r0_ready_o || r1_ready_o) begin
        checkOutput("dual_ready", 32'(r0_ready_o & r1_ready_o), 32'd0);
        if (sb.size() == 0) begin
          checkOutput("unexpected_ready", 32'(r0_ready_o | r1_ready_o), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("ready_req", 32'(r1_ready_o), e.req);
          checkOutput("done_cycle", cyc, e.done);
          checkOutput("rdata", (e.req == 1) ? 32'(r1_rdata_o) : 32'(r0_rdata_o), 32'(e.rdata));
          checkOutput("err", (e.req == 1) ? 32'(r1_err_o) : 32'(r0_err_o), 32'(e.err));
          checkOutput("other_side", (e.req == 1) ? 32'({r0_ready_o, r0_err_o, r0_rdata_o})
                                                 : 32'({r1_ready_o, r1_err_o, r1_rdata_o}), 32'd0);
          checkOutput("grant_resp", 32'(grant_o), e.req);
          checkOutput("busy_resp", 32'(busy_o), 32'd1);
        end
      end
      if (mem_valid_o) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_mem_valid", 32'(mem_valid_o), 32'd0);
        end else begin
          checkOutput("mem_wr_rd", 32'(mem_wr_rd_o), 32'(sb[0].wr));
          checkOutput("mem_addr", 32'(mem_addr_o), 32'(sb[0].addr));
          checkOutput("mem_wdata", 32'(mem_wdata_o), 32'(sb[0].wdata));
          checkOutput("grant_busy", {30'b0, grant_o, busy_o}, {30'b0, sb[0].req[0], 1'b1});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int            sel;
    bit            w0, w1;
    logic [AW-1:0] a0, a1;
    rst_i = 1'b1;
    r0_valid_i = 1'b0; r0_wr_rd_i = 1'b0; r0_addr_i = '0; r0_wdata_i = '0;
    r1_valid_i = 1'b0; r1_wr_rd_i = 1'b0; r1_addr_i = '0; r1_wdata_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < 1024; i++) begin
      storage[i] = DW'($urandom);
      ref_mem[i] = storage[i];
    end
    repeat (3) @(negedge clk_i);
    checkAllZero("reset");
    rst_i = 1'b0;

    // Tie: both requesters hold valid; grants must alternate starting with r0.
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    10'h011, 10'h022, DW'($urandom), DW'($urandom), 0);
    end

    // Single write then read-back of 0xBEEF at 0x005.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h005, '0, 16'hBEEF, '0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'h005, '0, 16'h1234, '0, 0);

    // Five-cycle memory stall, then ready landing exactly on the abort cycle.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h123, '0, 16'h5A5A, '0, 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 10'h123, '0, 16'h0F0F, TMO - 1);

    // Memory never answers: abort with err, then a normal request is still accepted.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 10'h005, '0, 16'hAAAA, 1000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 10'h005, '0, 16'h5555, 0);

    resetMidAccess();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'h123, 10'h3A7, '0, '0, 0);

    // Back-to-back requests from r1 only.
    for (int r = 0; r < 5; r++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), '0,
                    AW'($urandom_range(0, 15)), '0, DW'($urandom), 0);
    end

    for (int r = 0; r < 60; r++) begin
      sel = $urandom_range(1, 3);
      w0  = 1'($urandom_range(0, 1));
      w1  = 1'($urandom_range(0, 1));
      a0  = AW'($urandom_range(0, 15));
      a1  = AW'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      applyStimulus(sel[0], sel[1], w0, w1, a0, a1, DW'($urandom), DW'($urandom),
                    $urandom_range(0, 10));
    end

    repeat (4) @(negedge clk_i);
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
